// File: rtl/damping_pkg.sv
// Shared constants and state encoding for the damping low-pass filter.
package damping_pkg;

  localparam int unsigned DataWDefault = 24;
  localparam int unsigned CoefWDefault = 25;
  localparam int unsigned FracWDefault = 24;

  // Unity damping coefficient in Q1.24.
  localparam logic [24:0] COEF_ONE = 25'h100_0000;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StMulA = 2'd1;
  localparam state_t StMulB = 2'd2;
  localparam state_t StOut  = 2'd3;

endpackage

// File: rtl/damping_round_sat.sv
// Round-half-up, arithmetic shift by FRAC_W and saturate to signed DATA_W.
module damping_round_sat
  import damping_pkg::*;
#(
  parameter int unsigned ACC_W  = 51,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned FRAC_W = FracWDefault
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] data_o
);

  // One extra bit so the rounding add can never wrap.
  localparam int unsigned SumW = ACC_W + 1;

  logic signed [SumW-1:0]     half;
  logic signed [SumW-1:0]     sum;
  logic signed [SumW-1:0]     shifted;
  logic        [SumW-DATA_W:0] upper;

  // Round, shift, then clip anything outside the signed output range.
  always_comb begin
    half           = '0;
    half[FRAC_W-1] = 1'b1;
    sum            = $signed({acc_i[ACC_W-1], acc_i}) + half;
    shifted        = sum >>> FRAC_W;
    upper          = shifted[SumW-1:DATA_W-1];
    if ((&upper) || (~|upper)) begin
      data_o = shifted[DATA_W-1:0];
    end else if (shifted[SumW-1]) begin
      data_o = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      data_o = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/damping_lpf.sv
// One-pole damping filter y = x*(1-d) + y_prev*d, one sample per four cycles.
module damping_lpf
  import damping_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned COEF_W = CoefWDefault,
  parameter int unsigned FRAC_W = FracWDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [COEF_W-1:0] damping_value,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned ProdW = DATA_W + COEF_W + 1;
  localparam int unsigned AccW  = ProdW + 1;
  localparam logic [COEF_W-1:0] CoefOne = COEF_W'(1) << FRAC_W;

  state_t                   state_q, state_d;
  logic        [DATA_W-1:0] x_q, x_d;
  logic        [COEF_W-1:0] coef_q, coef_d;
  logic        [DATA_W-1:0] y_prev_q, y_prev_d;
  logic        [DATA_W-1:0] out_data_q, out_data_d;
  logic signed [ProdW-1:0]  prod_a_q, prod_a_d;

  logic        [COEF_W-1:0] coef_clamp;
  logic        [COEF_W-1:0] one_minus_d;
  logic signed [ProdW-1:0]  prod_b;
  logic signed [AccW-1:0]   acc;
  logic        [DATA_W-1:0] y_new;
  logic                     accept;

  assign in_ready  = reset_n && (state_q == StIdle) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);

  // Coefficient clamp and the two plain signed products (DSP-friendly).
  always_comb begin
    coef_clamp  = (damping_value > CoefOne) ? CoefOne : damping_value;
    one_minus_d = CoefOne - coef_q;
    prod_b      = ProdW'($signed(y_prev_q)) * ProdW'($signed({1'b0, coef_q}));
    acc         = AccW'(prod_a_q) + AccW'(prod_b);
  end

  damping_round_sat #(
    .ACC_W  (AccW),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc_i  (acc),
    .data_o (y_new)
  );

  // Sequencing: accept, multiply x, combine with feedback, hold until taken.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    coef_d     = coef_q;
    y_prev_d   = y_prev_q;
    out_data_d = out_data_q;
    prod_a_d   = prod_a_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d     = in_data;
          coef_d  = coef_clamp;
          state_d = StMulA;
        end
      end
      StMulA: begin
        prod_a_d = ProdW'($signed(x_q)) * ProdW'($signed({1'b0, one_minus_d}));
        state_d  = StMulB;
      end
      StMulB: begin
        out_data_d = y_new;
        y_prev_d   = y_new;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over any handshake in the same cycle.
    if (clear) begin
      state_d    = StIdle;
      y_prev_d   = '0;
      out_data_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      coef_q     <= '0;
      y_prev_q   <= '0;
      out_data_q <= '0;
      prod_a_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      coef_q     <= coef_d;
      y_prev_q   <= y_prev_d;
      out_data_q <= out_data_d;
      prod_a_q   <= prod_a_d;
    end
  end

endmodule

// File: tb/tb_damping_lpf.sv
// Directed plus randomised checks of the damping filter against a wide-integer model.
module tb_damping_lpf;

  logic        clk;
  logic        reset_n;
  logic [24:0] damping_value;
  logic        clear;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int          n_cmp;
  int          n_fail;
  logic [23:0] y_model;
  logic [23:0] sb[$];
  logic [23:0] got;

  damping_lpf dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .damping_value (damping_value),
    .clear         (clear),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact arithmetic in 64-bit integers, then round half up and saturate.
  function automatic logic [23:0] model(input logic [23:0] x, input logic [24:0] dv,
                                        input logic [23:0] yp);
    longint xs;
    longint ys;
    longint d;
    longint acc;
    longint r;
    xs  = longint'($signed(x));
    ys  = longint'($signed(yp));
    d   = longint'(dv);
    if (d > 64'sd16777216) d = 64'sd16777216;
    acc = xs * (64'sd16777216 - d) + ys * d;
    r   = (acc + 64'sd8388608) >>> 24;
    if (r > 64'sd8388607) r = 64'sd8388607;
    if (r < -64'sd8388608) r = -64'sd8388608;
    return r[23:0];
  endfunction

  // Full transaction: offer, track latency, optional backpressure, handshake.
  task automatic send(input logic [23:0] x, input logic [24:0] dv, input int hold,
                      output logic [23:0] result);
    int n;
    logic [23:0] exp;
    result = 'x;
    @(negedge clk);
    in_data       = x;
    damping_value = dv;
    in_valid      = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'(1'b1));
    exp     = model(x, dv, y_model);
    y_model = exp;
    sb.push_back(exp);
    @(negedge clk);
    in_valid      = 1'b0;
    in_data       = 24'($urandom);
    damping_value = 25'($urandom);
    check("busy_after_accept", 64'(busy), 64'(1'b1));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      damping_value = 25'($urandom);
      n++;
    end
    check("latency", 64'(n), 64'(2));
    if (out_valid) begin
      for (int i = 0; i < hold; i++) begin
        check("bp_out_valid", 64'(out_valid), 64'(1'b1));
        check("bp_in_ready", 64'(in_ready), 64'(1'b0));
        check("bp_out_data", 64'(out_data), 64'(sb[0]));
        @(negedge clk);
        damping_value = 25'($urandom);
      end
      out_ready = 1'b1;
      result    = out_data;
      check("out_data", 64'(out_data), 64'(sb.pop_front()));
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_valid", 64'(out_valid), 64'(1'b0));
      check("idle_in_ready", 64'(in_ready), 64'(1'b1));
      check("idle_busy", 64'(busy), 64'(1'b0));
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    y_model       = '0;
    reset_n       = 1'b0;
    clear         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    damping_value = '0;
    out_ready     = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_in_ready", 64'(in_ready), 64'(1'b0));
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1'b1));

    // Pass-through.
    send(24'h100000, 25'h0, 0, got);
    check("pass_through", 64'(got), 64'(24'h100000));

    // Hold with d = 1.0 and a clamped oversize coefficient.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    y_model = '0;
    send(24'h7FFFFF, 25'h1000000, 0, got);
    check("hold_unity", 64'(got), 64'(24'h000000));
    send(24'h7FFFFF, 25'h1FFFFFF, 0, got);
    check("hold_clamp", 64'(got), 64'(24'h000000));

    // Step response at d = 0.5, then back to pass-through with a negative sample.
    send(24'h400000, 25'h800000, 0, got);
    check("step_1", 64'(got), 64'(24'h200000));
    send(24'h400000, 25'h800000, 0, got);
    check("step_2", 64'(got), 64'(24'h300000));
    send(24'h400000, 25'h800000, 0, got);
    check("step_3", 64'(got), 64'(24'h380000));
    send(24'hFFFFFF, 25'h0, 0, got);
    check("step_neg", 64'(got), 64'(24'hFFFFFF));

    // Backpressure with the coefficient changing during the hold.
    send(24'h123456, 25'h400000, 5, got);

    // Clear while idle blocks acceptance.
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("clear_in_ready", 64'(in_ready), 64'(1'b0));
    @(negedge clk);
    clear = 1'b0;
    y_model = '0;
    send(24'h200000, 25'h0, 0, got);

    // Clear during the second multiply stage.
    @(negedge clk);
    in_data       = 24'h654321;
    damping_value = 25'h0;
    in_valid      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_out_valid", 64'(out_valid), 64'(1'b0));
    check("clr_out_data", 64'(out_data), 64'(0));
    check("clr_busy", 64'(busy), 64'(1'b0));
    repeat (3) @(negedge clk);
    check("clr_no_output", 64'(out_valid), 64'(1'b0));
    y_model = '0;
    send(24'h400000, 25'h800000, 0, got);
    check("clr_y_prev_zero", 64'(got), 64'(24'h200000));

    // Reset pulse while the result is waiting.
    @(negedge clk);
    in_data       = 24'h654321;
    damping_value = 25'h0;
    in_valid      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("rst_reached_out", 64'(out_valid), 64'(1'b1));
    reset_n = 1'b0;
    #1;
    check("rstout_out_valid", 64'(out_valid), 64'(1'b0));
    check("rstout_out_data", 64'(out_data), 64'(0));
    check("rstout_in_ready", 64'(in_ready), 64'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rstout_rel_ready", 64'(in_ready), 64'(1'b1));
    repeat (3) @(negedge clk);
    check("rstout_no_output", 64'(out_valid), 64'(1'b0));
    y_model = '0;
    send(24'h400000, 25'h800000, 0, got);
    check("rst_y_prev_zero", 64'(got), 64'(24'h200000));

    // Extremes: full-scale positive and negative must not wrap.
    send(24'h7FFFFF, 25'h0, 0, got);
    send(24'h7FFFFF, 25'h800000, 0, got);
    check("sat_pos", 64'(got), 64'(24'h7FFFFF));
    send(24'h800000, 25'h0, 0, got);
    send(24'h800000, 25'h1000000, 0, got);
    check("sat_neg", 64'(got), 64'(24'h800000));

    // Random samples and coefficients, including clamped ones.
    for (int i = 0; i < 10; i++) begin
      send(24'($urandom), 25'($urandom_range(0, 32'h1100000)), i % 3, got);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/damping_lpf.md
DAMPING_LPF -- requirements
Module: damping_lpf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, meaning the signed audio sample width.
REQ-002 The block SHALL have parameter COEF_W, default 25, meaning the damping coefficient width (unsigned Q1.24, 0x1000000 = 1.0).
REQ-003 The block SHALL have parameter FRAC_W, default 24, meaning the coefficient fractional bits.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port damping_value, input, COEF_W bits, the damping coefficient from the damping PIO out_port, in the clk domain.
REQ-007 The block SHALL have port clear, input, 1 bit, a synchronous flush of the filter state.
REQ-008 The block SHALL have port in_data, input, DATA_W bits, the signed input sample.
REQ-009 The block SHALL have port in_valid, input, 1 bit, input sample present.
REQ-010 The block SHALL have port in_ready, output, 1 bit, block accepts a sample.
REQ-011 The block SHALL have port out_data, output, DATA_W bits, the signed filtered sample.
REQ-012 The block SHALL have port out_valid, output, 1 bit, out_data valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, downstream accepts the sample.
REQ-014 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-015 The block SHALL compute the one-pole damping filter y[n] = x[n]*(1-d) + y[n-1]*d.
REQ-016 When damping_value > 0x1000000, d SHALL be clamped to 0x1000000.
REQ-017 The FSM SHALL have four states: IDLE, MUL_A, MUL_B, OUT.
REQ-018 In IDLE, in_ready SHALL be 1 unless clear=1; in all other states, in_ready SHALL be 0.
REQ-019 When in_valid & in_ready at an edge: x is latched, the clamped d is latched, and the FSM goes IDLE->MUL_A.
REQ-020 damping_value changes after acceptance SHALL NOT affect the sample in flight.
REQ-021 In MUL_A, the FSM SHALL register prod_a = x * (2^FRAC_W - d) as a signed product of DATA_W+COEF_W+1 bits, then go to MUL_B.
REQ-022 In MUL_B, the FSM SHALL form acc = prod_a + y_prev*d (one guard bit), round by adding 2^(FRAC_W-1), arithmetic-shift right FRAC_W, and saturate to the signed DATA_W range.
REQ-023 The MUL_B step SHALL register the result into out_data and y_prev, then go to OUT.
REQ-024 Latency: out_valid SHALL rise on the 3rd rising edge after the accepting edge (accept edge, MUL_A edge, MUL_B edge).
REQ-025 In OUT, out_valid SHALL be 1, and out_data SHALL be held stable until out_valid & out_ready.
REQ-026 When out_valid & out_ready at an edge, the FSM SHALL go to IDLE, with out_valid=0 next cycle.
REQ-027 Throughput: at most one sample per 4 cycles; no input is accepted in the same cycle as the output handshake.
REQ-028 clear=1 at an edge in any state SHALL force: IDLE, y_prev=0, out_valid=0, out_data=0.
REQ-029 clear SHALL have priority over in_valid and out_ready.
REQ-030 d=0 SHALL give y = x exactly; d=1.0 SHALL give y = y_prev exactly, with no rounding drift.

Reset
REQ-031 While reset_n=0, the block SHALL set: state=IDLE, out_valid=0, out_data=0, y_prev=0, latched x=0, latched d=0, busy=0.
REQ-032 in_ready SHALL be 0 while reset_n=0 and 1 in the first cycle after release.
REQ-033 A reset asserted mid-operation SHALL discard the in-flight sample, with no output produced.

Structure
REQ-034 Package damping_pkg SHALL hold: DATA_W/COEF_W/FRAC_W defaults, COEF_ONE=0x1000000, and the state enum (IDLE, MUL_A, MUL_B, OUT).
REQ-035 Round-and-saturate SHALL be a sub-module, damping_round_sat (input acc, output DATA_W), and SHALL be purely combinational.
REQ-036 Multiplies SHALL be written as plain signed products so DSP blocks are inferred; there SHALL be no vendor primitives.

Verification
REQ-037 Pass-through: d=0, x=0x100000 -> out_data=0x100000 on the 3rd edge after accept; out_ready=1 gives IDLE on the next edge.
REQ-038 Hold: d=0x1000000 after reset, x=0x7FFFFF -> out_data=0x000000; d=0x1FFFFFF behaves identically (clamp).
REQ-039 Step: d=0x800000 with x=0x400000 three times -> outputs 0x200000, 0x300000, 0x380000; then x=0xFFFFFF with d=0 -> 0xFFFFFF.
REQ-040 Backpressure: out_ready=0 for 5 cycles -> out_data and out_valid stable and in_ready=0; damping_value changed during this window does not alter the result.
REQ-041 Clear/reset mid-operation: clear in MUL_B -> no out_valid, next sample sees y_prev=0; reset_n pulse in OUT gives the same result.
REQ-042 Saturation: force y_prev=0x7FFFFF, d=0x800000, x=0x7FFFFF -> out_data=0x7FFFFF with no wrap.
